apb_const_reader: RTL and testbench

APB-style requester that drives the bus toward the constant-register peripheral and gathers its 64-bit split read data. A local command port issues one transfer at a time. The block sequences the PSEL/PENABLE phases, waits on PREADY with a bounded timeout, and assembles {PRWDATA1, PRWDATA2} into a 64-bit response. It sits between the control logic and the peripheral, in place of the testbench-driven bus.

---
 rtl/apb_const_reader_pkg.sv | 22 ++
 rtl/apb_const_reader_if.sv | 29 ++
 rtl/apb_const_reader_wait_timer.sv | 33 +++
 rtl/apb_const_reader.sv | 119 +++++++++++
 tb/tb_apb_const_reader.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_const_reader_pkg.sv
// rtl/apb_const_reader_pkg.sv - shared types and constants for the APB constant-register reader
//
// Purpose : FSM state encoding, peripheral register addresses and the reference
//           value of the PI register.
// Contents: state_t, ADDR_PI, ADDR_E, PI_BITS.

package apb_const_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_PI = 32'h4;
  localparam logic [31:0] ADDR_E  = 32'h8;

  // IEEE-754 double of 3.1415
  localparam logic [63:0] PI_BITS = 64'h400921CAC083126F;

endpackage

// File: rtl/apb_const_reader_if.sv
// rtl/apb_const_reader_if.sv - APB-style bus toward the constant-register peripheral
//
// Purpose : bundles the requester/peripheral bus signals.
// Ports   : master - drives PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA;
//                    samples PRWDATA1 (upper word), PRWDATA2 (lower word), PREADY.
//           slave  - the mirror image.

interface apb_const_if;

  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRWADDR;
  logic [31:0] PRWDATA;
  logic [31:0] PRWDATA1;
  logic [31:0] PRWDATA2;
  logic        PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA,
    input  PRWDATA1, PRWDATA2, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA,
    output PRWDATA1, PRWDATA2, PREADY
  );

endinterface

// File: rtl/apb_const_reader_wait_timer.sv
// rtl/apb_const_reader_wait_timer.sv - saturating ACCESS-phase wait counter
//
// Purpose : counts ACCESS cycles spent waiting for PREADY.
// Ports   : PCLK, PRESET (async, active-high)
//           clr     - zero the count (takes priority over en)
//           en      - advance the count by one, saturating at 8'hFF
//           expired - count has reached TIMEOUT-1

module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic PCLK,
  input  logic PRESET,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/apb_const_reader.sv
// rtl/apb_const_reader.sv - single-outstanding APB requester with 64-bit split read data
//
// Purpose : accepts one command at a time, runs SETUP/ACCESS on the bus, waits
//           for PREADY up to TIMEOUT ACCESS cycles and returns {PRWDATA1, PRWDATA2}.
// Ports   : PCLK, PRESET (async, active-high)
//           cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command request
//           rsp_valid/rsp_ready/rsp_data/rsp_err             - response, held until consumed
//           apb (apb_const_if.master)                        - peripheral bus
// Every output is decoded from, or is, a register; no input reaches an output
// combinationally.

module apb_const_reader
  import apb_const_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [31:0]        cmd_addr,
  input  logic [31:0]        cmd_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  output logic               rsp_err,
  apb_const_if.master        apb
);

  state_t      state, state_nxt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [63:0] rsp_data_q;
  logic        rsp_err_q;
  logic        timer_clr;
  logic        timer_en;
  logic        expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (expired)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        timer_clr = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // PREADY is checked before expiry so a late ready still completes
        if (apb.PREADY || expired) begin
          state_nxt = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      write_q    <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rsp_data_q <= 64'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        write_q <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (state == ACCESS) begin
        if (apb.PREADY) begin
          rsp_data_q <= write_q ? 64'd0 : {apb.PRWDATA1, apb.PRWDATA2};
          rsp_err_q  <= 1'b0;
        end else if (expired) begin
          rsp_data_q <= 64'd0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign apb.PSEL    = (state == SETUP) || (state == ACCESS);
  assign apb.PENABLE = (state == ACCESS);
  assign apb.PWRITE  = write_q;
  assign apb.PRWADDR = addr_q;
  assign apb.PRWDATA = wdata_q;

endmodule

// File: tb/tb_apb_const_reader.sv
// tb/tb_apb_const_reader.sv - scoreboard bench for apb_const_reader

module tb_apb_const_reader;
  import apb_const_pkg::*;

  localparam int T = 16;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;

  apb_const_if bus();

  apb_const_reader #(.TIMEOUT(T)) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .apb       (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Posedge counter; read at negedges only.
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Peripheral: PREADY rises after cur_wait ACCESS cycles; stale_en drives
  // PREADY high whenever the bus is not in ACCESS.
  int acc = 0;
  int cur_wait = 0;
  bit stale_en = 1'b0;
  always @(posedge PCLK) begin
    if (bus.PSEL && bus.PENABLE) acc <= acc + 1;
    else                         acc <= 0;
  end

  function automatic logic [63:0] periph_word(input logic [31:0] a);
    if (a == ADDR_PI)     return PI_BITS;
    else if (a == ADDR_E) return $realtobits(2.7182);
    else                  return {~a, a ^ 32'h5A5A_0000};
  endfunction

  always_comb begin
    bus.PREADY = (bus.PSEL && bus.PENABLE) ? (acc == cur_wait) : stale_en;
    {bus.PRWDATA1, bus.PRWDATA2} = periph_word(bus.PRWADDR);
  end

  // Reference model: what a read of each register must return.
  function automatic logic [63:0] ref_value(input logic [31:0] a);
    if (a == 32'h4)      return $realtobits(3.1415);
    else if (a == 32'h8) return $realtobits(2.7182);
    else                 return {~a, a ^ 32'h5A5A_0000};
  endfunction

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          edge_n;
    int          psel_n;
  } exp_t;

  exp_t exp_q[$];

  logic        cur_write = 1'b0;
  logic [31:0] cur_addr  = 32'd0;
  logic [31:0] cur_wdata = 32'd0;

  // Push expectation for a command accepted on the next posedge.
  task automatic push_exp(input bit wr, input logic [31:0] a, input int w);
    exp_t e;
    int   lat;
    e.err    = (w >= T);
    e.data   = (e.err || wr) ? 64'd0 : ref_value(a);
    // SETUP, then w+1 ACCESS cycles, or T ACCESS cycles on timeout
    lat      = e.err ? 1 + T : 2 + w;
    e.edge_n = cyc + 1 + lat;
    e.psel_n = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each response against the scoreboard when it appears,
  // plus bus fields while PSEL is high.
  bit rsp_seen = 1'b0;
  int psel_cnt = 0;
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET) begin
      rsp_seen = 1'b0;
      psel_cnt = 0;
    end else begin
      if (bus.PSEL) begin
        psel_cnt++;
        chk("bus_fields", {bus.PWRITE, bus.PRWADDR, bus.PRWDATA},
            {cur_write, cur_addr, cur_wdata});
      end
      if (rsp_valid && !rsp_seen) begin
        rsp_seen = 1'b1;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %0h err %0b, want none", rsp_data, rsp_err);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk("rsp_edge", 64'(cyc), 64'(e.edge_n));
          chk("psel_cycles", 64'(psel_cnt), 64'(e.psel_n));
        end
        psel_cnt = 0;
      end else if (!rsp_valid) begin
        rsp_seen = 1'b0;
      end
    end
  end

  task automatic wait_rsp(output bit ok);
    int g = 0;
    while (!rsp_valid && g < 80) begin
      @(negedge PCLK);
      g++;
    end
    ok = rsp_valid;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_wait_bound: got no rsp_valid, want rsp_valid within 80 cycles");
    end
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input int w, input bit stale);
    int g = 0;
    while (!cmd_ready && g < 80) begin
      @(negedge PCLK);
      g++;
    end
    cur_wait  = w;
    stale_en  = stale;
    cur_write = wr;
    cur_addr  = a;
    cur_wdata = wd;
    push_exp(wr, a, w);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input int w, input bit stale, input int rdly);
    bit ok;
    bit busy_ok = 1'b1;
    issue(wr, a, wd, w, stale);
    while (!rsp_valid && busy_ok) begin
      if (cmd_ready) busy_ok = 1'b0;
      wait_rsp(ok);
      if (!ok) return;
    end
    repeat (rdly) begin
      if (cmd_ready) busy_ok = 1'b0;
      @(negedge PCLK);
    end
    chk("cmd_ready_busy", 64'(busy_ok), 64'd1);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("cmd_ready_after_rsp", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1);
  end

  initial begin
    bit          ok;
    bit          quiet;
    bit          stable;
    logic [63:0] held;
    int          w;
    logic [31:0] a;

    // Reset values
    repeat (2) @(negedge PCLK);
    chk("reset_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PRWADDR, bus.PRWDATA}, 64'd0);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_rsp", {rsp_valid, rsp_err}, 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Constant peripheral reads, one-wait PREADY
    do_xfer(1'b0, ADDR_PI, 32'h0, 1, 1'b0, 0);
    do_xfer(1'b0, ADDR_E, 32'h0, 1, 1'b0, 2);
    // Write with PREADY never arriving -> timeout
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 100, 1'b0, 1);
    // Stale PREADY outside ACCESS, one-wait and zero-wait
    do_xfer(1'b0, ADDR_PI, 32'h0, 1, 1'b1, 0);
    do_xfer(1'b0, ADDR_E, 32'h0, 0, 1'b1, 0);
    // PREADY on the timeout edge wins; one later is a timeout
    do_xfer(1'b0, ADDR_PI, 32'h0, T - 1, 1'b0, 0);
    do_xfer(1'b0, ADDR_PI, 32'h0, T, 1'b1, 0);

    // Reset in the second ACCESS cycle
    cur_wait  = 100;
    stale_en  = 1'b0;
    cur_write = 1'b0;
    cur_addr  = ADDR_PI;
    cur_wdata = 32'h0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = ADDR_PI;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk("reset_mid_psel", {bus.PSEL, bus.PENABLE}, 64'd0);
    chk("reset_mid_state", {cmd_ready, rsp_valid}, 64'h2);
    @(negedge PCLK);
    PRESET = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge PCLK);
      if (rsp_valid || bus.PSEL) quiet = 1'b0;
    end
    chk("reset_dropped", 64'(quiet), 64'd1);
    do_xfer(1'b0, ADDR_PI, 32'h0, 1, 1'b0, 0);

    // Response stall with ignored commands, then back-to-back command
    issue(1'b0, ADDR_E, 32'h0, 1, 1'b0);
    wait_rsp(ok);
    held   = rsp_data;
    stable = ok;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = i[0];
      cmd_write = 1'b1;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      @(negedge PCLK);
      if (!rsp_valid || (rsp_data !== held) || cmd_ready) stable = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("stall_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    do_xfer(1'b0, ADDR_PI, 32'h0, 1, 1'b0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       w = 0;
        1, 2:    w = 1;
        3:       w = $urandom_range(2, 14);
        4:       w = $urandom_range(T - 1, T);
        default: w = $urandom_range(T + 1, 30);
      endcase
      case ($urandom_range(0, 2))
        0:       a = ADDR_PI;
        1:       a = ADDR_E;
        default: a = $urandom;
      endcase
      do_xfer(1'($urandom_range(0, 1)), a, $urandom, w,
              1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    repeat (5) @(negedge PCLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
